// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default protection and strobe width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_requester.sv
// APB4 requester: accepts single commands, runs SETUP/ACCESS, returns a response strobe.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | bus parked at 0, cmd_ready high, command latched on accept
//   SETUP  | psel=1, penable=0 for exactly one cycle
//   ACCESS | psel=1, penable=1, waiting on pready or the wait timeout
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                pclk,
    input  logic                                preset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [ADDR_WIDTH-1:0]               cmd_addr,
    input  logic [DATA_WIDTH-1:0]               cmd_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0]   cmd_strb,
    input  logic [2:0]                          cmd_prot,
    output logic                                rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_error,
    output logic                                rsp_timeout,
    output logic                                psel,
    output logic                                penable,
    output logic                                pwrite,
    output logic [ADDR_WIDTH-1:0]               paddr,
    output logic [2:0]                          pprot,
    output logic [DATA_WIDTH-1:0]               pwdata,
    output logic [strb_width(DATA_WIDTH)-1:0]   pstrb,
    input  logic                                pready,
    input  logic [DATA_WIDTH-1:0]               prdata,
    input  logic                                pslverr
);

    localparam int SW    = strb_width(DATA_WIDTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Abort fires while the counter shows the last permitted wait cycle,
    // so exactly TIMEOUT_CYCLES ACCESS cycles appear on the bus.
    localparam logic [CNT_W-1:0] TC_LAST =
        TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb_state_e              state, state_nxt;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [2:0]              pprot_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt;
    logic [SW-1:0]           pstrb_nxt;
    logic                    rsp_valid_nxt, rsp_error_nxt, rsp_timeout_nxt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;

    assign cmd_ready = (state == ST_IDLE) && !preset;

    // State, counter and all bus/response outputs are registered here.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pprot       <= APB_PROT_DEFAULT;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            pwrite      <= pwrite_nxt;
            paddr       <= paddr_nxt;
            pprot       <= pprot_nxt;
            pwdata      <= pwdata_nxt;
            pstrb       <= pstrb_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_error   <= rsp_error_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

    // Next-state, bus field and response computation.
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        psel_nxt        = psel;
        penable_nxt     = penable;
        pwrite_nxt      = pwrite;
        paddr_nxt       = paddr;
        pprot_nxt       = pprot;
        pwdata_nxt      = pwdata;
        pstrb_nxt       = pstrb;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_error_nxt   = rsp_error;
        rsp_timeout_nxt = rsp_timeout;

        unique case (state)
            ST_IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                pwrite_nxt  = 1'b0;
                paddr_nxt   = '0;
                pprot_nxt   = APB_PROT_DEFAULT;
                pwdata_nxt  = '0;
                pstrb_nxt   = '0;
                if (cmd_valid && cmd_ready) begin
                    state_nxt    = ST_SETUP;
                    wait_cnt_nxt = '0;
                    psel_nxt     = 1'b1;
                    pwrite_nxt   = cmd_write;
                    paddr_nxt    = cmd_addr;
                    pprot_nxt    = cmd_prot;
                    // Reads never carry data or strobes on the bus.
                    pwdata_nxt   = cmd_write ? cmd_wdata : '0;
                    pstrb_nxt    = cmd_write ? cmd_strb  : '0;
                end
            end
            ST_SETUP: begin
                state_nxt   = ST_ACCESS;
                penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (pready || (TIMEOUT_EN && wait_cnt == TC_LAST)) begin
                    state_nxt       = ST_IDLE;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    pwrite_nxt      = 1'b0;
                    paddr_nxt       = '0;
                    pprot_nxt       = APB_PROT_DEFAULT;
                    pwdata_nxt      = '0;
                    pstrb_nxt       = '0;
                    rsp_valid_nxt   = 1'b1;
                    // pready takes priority over a coincident timeout.
                    rsp_rdata_nxt   = (pready && !pwrite) ? prdata : '0;
                    rsp_error_nxt   = pready ? pslverr : 1'b1;
                    rsp_timeout_nxt = !pready;
                end else if (wait_cnt != '1) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a small behavioural APB completer.
module tb_apb_requester;

    logic       pclk = 1'b0;
    logic       preset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [0:0] cmd_strb;
    logic [2:0] cmd_prot;
    logic       rsp_valid, rsp_error, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [3:0] paddr;
    logic [2:0] pprot;
    logic [7:0] pwdata;
    logic [0:0] pstrb;
    logic       pready, pslverr;
    logic [7:0] prdata;

    int checks = 0;
    int errors = 0;

    apb_requester #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pprot(pprot),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Behavioural completer: programmable wait states, stuck mode, error on writes to 0xF.
    logic       tb_init;
    logic       stuck;
    int         wait_target;
    int         acc_cnt;
    logic [7:0] mem [16];

    assign pready  = psel && penable && !stuck && (acc_cnt >= wait_target);
    assign prdata  = mem[paddr];
    assign pslverr = psel && penable && pwrite && (paddr == 4'hF);

    always @(posedge pclk) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem[5]  <= 8'h3C;
            acc_cnt <= 0;
        end else begin
            if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
            else                            acc_cnt <= 0;
            if (psel && penable && pready && pwrite && pstrb[0] && paddr != 4'hF)
                mem[paddr] <= pwdata;
        end
    end

    // Bus monitor: accepted commands, response pulses and read-strobe rule.
    int         n_accept = 0;
    int         n_rsp    = 0;
    logic       read_strb_bad = 1'b0;
    logic [7:0] rsp_q [$];

    always @(posedge pclk) begin
        if (!preset && cmd_valid && cmd_ready) n_accept++;
        if (rsp_valid) begin
            n_rsp++;
            rsp_q.push_back(rsp_rdata);
        end
        if (psel && !pwrite && pstrb != 1'b0) read_strb_bad = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one command and follows it to its response, noting bus timing.
    task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                          input logic strb,
                          output int t_rsp, output int t_psel, output int t_pen, output int t_acc,
                          output logic stable, output logic psel_at_rsp,
                          output logic [7:0] rdata, output logic err, output logic to);
        logic [3:0] a0;
        logic       w0;
        int         n;
        int         guard;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = 3'b010;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        n = 1; t_psel = -1; t_pen = -1; t_acc = 0; stable = 1'b1;
        a0 = paddr; w0 = pwrite;
        while (!rsp_valid && n < 60) begin
            if (psel && t_psel < 0) t_psel = n;
            if (penable && t_pen < 0) t_pen = n;
            if (psel && penable) t_acc++;
            if (psel && (paddr != a0 || pwrite != w0)) stable = 1'b0;
            @(negedge pclk);
            n++;
        end
        t_rsp = rsp_valid ? n : -1;
        psel_at_rsp = psel;
        rdata = rsp_rdata; err = rsp_error; to = rsp_timeout;
    endtask

    int         t_rsp, t_psel, t_pen, t_acc;
    logic       stable, psel_rsp, err, to;
    logic [7:0] rdata;
    int         base_acc, base_rsp, base_q, idx, guard;
    logic       will_accept;
    logic [3:0] q_addr [3];
    logic [7:0] q_data [3];
    logic       q_wr   [3];

    initial begin
        preset = 1'b1; tb_init = 1'b1; stuck = 1'b0; wait_target = 0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0;
        repeat (3) @(negedge pclk);

        // Reset state
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_bus", {pwrite, paddr, pprot, pwdata, pstrb}, 0);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout}, 0);
        preset = 1'b0; tb_init = 1'b0;
        @(negedge pclk);
        check("rdy_after_rst", cmd_ready, 1);

        // Write 0xA5 to addr 3, zero wait states
        do_cmd(1'b1, 4'h3, 8'hA5, 1'b1, t_rsp, t_psel, t_pen, t_acc, stable, psel_rsp, rdata, err, to);
        check("wr_psel_lat", t_psel, 1);
        check("wr_pen_lat", t_pen, 2);
        check("wr_rsp_lat", t_rsp, 3);
        check("wr_err", err, 0);
        check("wr_rdata", rdata, 0);

        // Read it back
        do_cmd(1'b0, 4'h3, 8'h00, 1'b0, t_rsp, t_psel, t_pen, t_acc, stable, psel_rsp, rdata, err, to);
        check("rd_rsp_lat", t_rsp, 3);
        check("rd_rdata", rdata, 8'hA5);
        check("rd_err", err, 0);

        // Four wait states, read 0x3C from addr 5
        wait_target = 4;
        do_cmd(1'b0, 4'h5, 8'h00, 1'b0, t_rsp, t_psel, t_pen, t_acc, stable, psel_rsp, rdata, err, to);
        check("ws_rsp_lat", t_rsp, 7);
        check("ws_access_cycles", t_acc, 5);
        check("ws_rdata", rdata, 8'h3C);
        check("ws_stable", stable, 1);
        wait_target = 0;

        // Slave error on write to 0xF
        do_cmd(1'b1, 4'hF, 8'h77, 1'b1, t_rsp, t_psel, t_pen, t_acc, stable, psel_rsp, rdata, err, to);
        check("slverr_err", err, 1);
        check("slverr_to", to, 0);
        check("slverr_rdata", rdata, 0);

        // Queued commands with cmd_valid held high
        q_wr[0] = 1'b1; q_addr[0] = 4'h1; q_data[0] = 8'h11;
        q_wr[1] = 1'b1; q_addr[1] = 4'h2; q_data[1] = 8'h22;
        q_wr[2] = 1'b0; q_addr[2] = 4'h1; q_data[2] = 8'hEE;
        @(negedge pclk);
        base_acc = n_accept; base_rsp = n_rsp; base_q = rsp_q.size();
        idx = 0; guard = 0;
        cmd_valid = 1'b1; cmd_write = q_wr[0]; cmd_addr = q_addr[0];
        cmd_wdata = q_data[0]; cmd_strb = 1'b1;
        while (idx < 3 && guard < 60) begin
            will_accept = cmd_ready;
            @(negedge pclk);
            guard++;
            if (will_accept) begin
                idx++;
                if (idx == 3) cmd_valid = 1'b0;
                else begin
                    cmd_write = q_wr[idx]; cmd_addr = q_addr[idx];
                    cmd_wdata = q_data[idx]; cmd_strb = 1'b1;
                end
            end
        end
        guard = 0;
        while (n_rsp < base_rsp + 3 && guard < 40) begin
            @(negedge pclk);
            guard++;
        end
        repeat (5) @(negedge pclk);
        check("q_accepts", n_accept - base_acc, 3);
        check("q_rsp_pulses", n_rsp - base_rsp, 3);
        check("q_wr_rdata", (rsp_q.size() > base_q) ? rsp_q[base_q] : 8'hFF, 0);
        check("q_rd_rdata", (rsp_q.size() > base_q + 2) ? rsp_q[base_q + 2] : 8'hFF, 8'h11);
        check("q_rd_strb_zero", read_strb_bad, 0);

        // Stuck completer: timeout after 16 ACCESS cycles
        stuck = 1'b1;
        do_cmd(1'b0, 4'h2, 8'h00, 1'b0, t_rsp, t_psel, t_pen, t_acc, stable, psel_rsp, rdata, err, to);
        check("to_access_cycles", t_acc, 16);
        check("to_rsp_lat", t_rsp, 18);
        check("to_psel", psel_rsp, 0);
        check("to_err", err, 1);
        check("to_flag", to, 1);
        check("to_rdata", rdata, 0);
        stuck = 1'b0;
        do_cmd(1'b0, 4'h2, 8'h00, 1'b0, t_rsp, t_psel, t_pen, t_acc, stable, psel_rsp, rdata, err, to);
        check("post_to_rdata", rdata, 8'h22);
        check("post_to_flag", to, 0);
        check("post_to_lat", t_rsp, 3);

        // Reset during ACCESS of a write to addr 3
        wait_target = 10;
        @(negedge pclk);
        base_rsp = n_rsp;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 8'h5A; cmd_strb = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        check("pre_rst_in_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        @(negedge pclk);
        check("midrst_psel", psel, 0);
        check("midrst_penable", penable, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        preset = 1'b0;
        @(negedge pclk);
        check("midrst_ready_after", cmd_ready, 1);
        repeat (3) @(negedge pclk);
        check("midrst_no_rsp", n_rsp - base_rsp, 0);
        wait_target = 0;
        do_cmd(1'b0, 4'h3, 8'h00, 1'b0, t_rsp, t_psel, t_pen, t_acc, stable, psel_rsp, rdata, err, to);
        check("midrst_old_data", rdata, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
